adder_chunked: RTL

ADDER_CHUNKED -- requirements
Module: adder_chunked

---
 rtl/adder_pkg.sv | 14 +
 rtl/adder_chunk.sv | 32 +++
 rtl/adder_chunked.sv | 126 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the chunked serial adder/subtractor.
// Holds the controller state encoding and the default operand/chunk widths.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CHUNK = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice used once per cycle by adder_chunked.
// Ports:
//   a, b     : CHUNK-bit operand slices
//   cin      : carry into bit 0 of the slice
//   s        : CHUNK-bit sum of the slice
//   cout     : carry out of the slice's top bit
//   c_msb_in : carry into the slice's top bit (for signed overflow)
module adder_chunk #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0]   full_c;
  logic [CHUNK-1:0] low_c;

  // Full slice sum; the extra bit is the carry out.
  assign full_c = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(cin);

  // Sum of all bits below the top one; its top bit is the carry into the MSB.
  assign low_c = CHUNK'(a[CHUNK-2:0]) + CHUNK'(b[CHUNK-2:0]) + CHUNK'(cin);

  assign s        = full_c[CHUNK-1:0];
  assign cout     = full_c[CHUNK];
  assign c_msb_in = low_c[CHUNK-1];

endmodule

// File: rtl/adder_chunked.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock.
// Operands are accepted in IDLE, added LSB chunk first over N = WIDTH/CHUNK
// cycles in CALC, and the result is held in DONE until the consumer takes it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (ready only in IDLE)
//   a, b, sub           : operands; sub=1 computes a-b
//   out_valid, out_ready: result handshake (valid only in DONE)
//   sum                 : result modulo 2^WIDTH
//   carry_out           : unsigned carry (for sub, 1 = no borrow)
//   overflow            : two's-complement signed overflow
module adder_chunked
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned   N    = WIDTH / CHUNK;
  localparam int unsigned   CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (CHUNK < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("adder_chunked: WIDTH must be a multiple of CHUNK and CHUNK >= 2");
  end

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry;
  logic [CW-1:0]    k;

  logic [CHUNK-1:0]       s_c;
  logic                   cout_c;
  logic                   c_msb_c;
  logic [WIDTH+CHUNK-1:0] res_shift_c;

  // Operand registers shift right each CALC cycle, so the active chunk is
  // always in the low bits; result chunks enter from the top.
  adder_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a        (a_r[CHUNK-1:0]),
    .b        (b_r[CHUNK-1:0]),
    .cin      (carry),
    .s        (s_c),
    .cout     (cout_c),
    .c_msb_in (c_msb_c)
  );

  assign res_shift_c = {s_c, res_r};

  // Controller, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      carry     <= 1'b0;
      k         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            // a - b = a + ~b + 1: invert b and seed the carry with sub.
            b_r      <= sub ? ~b : b;
            carry    <= sub;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          a_r   <= a_r >> CHUNK;
          b_r   <= b_r >> CHUNK;
          res_r <= res_shift_c[WIDTH+CHUNK-1:CHUNK];
          carry <= cout_c;
          if (k == LAST) begin
            k         <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= res_shift_c[WIDTH+CHUNK-1:CHUNK];
            carry_out <= cout_c;
            overflow  <= c_msb_c ^ cout_c;
          end else begin
            k <= k + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
